tp_sdiv_32s_17s_18s_seq: RTL and testbench

Sequential signed integer divider: the inverse of the 18s x 17s -> 32s DSP multiplier used in the TrackletProcessor.
- Takes a 32-bit signed dividend and a 17-bit signed divisor.
- Returns an 18-bit signed quotient (truncated toward zero) and a 17-bit signed remainder.
- Uses a radix-2 restoring iteration, one quotient bit per cycle, with valid/ready handshakes on both sides.
- Intended for projection/inverse-radius rescaling paths where divides are infrequent and area matters more than throughput.

---
 rtl/tp_div_pkg.sv | 23 ++
 rtl/tp_div_step.sv | 25 ++
 rtl/tp_sdiv_32s_17s_18s_seq.sv | 173 +++++++++++++++++
 tb/tb_tp_sdiv_32s_17s_18s_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tp_div_pkg.sv
// Shared constants and state type for the sequential signed divider.
package tp_div_pkg;

  // Default widths: inverse of the 18s x 17s -> 32s multiplier.
  localparam int DEF_DIVIDEND_W = 32;
  localparam int DEF_DIVISOR_W  = 17;
  localparam int DEF_QUOT_W     = 18;

  // Saturation bounds of an 18-bit signed quotient.
  localparam int QUOT_MAX = 131071;
  localparam int QUOT_MIN = -131072;

  // Width of the iteration counter for the default dividend width.
  localparam int CNT_W = $clog2(DEF_DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/tp_div_step.sv
// One restoring-division step on unsigned magnitudes.
// The remainder is always below |divisor| <= 2^(W-1), so W bits hold it.
module tp_div_step #(
  parameter int W = 17
) (
  input  logic [W-1:0] rem_in,
  input  logic         next_bit,
  input  logic [W-1:0] divisor_mag,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0]   w_partial;
  logic [W-1:0] w_diff;

  // Shift the next dividend bit into the partial remainder.
  assign w_partial = {rem_in, next_bit};

  // Whenever the subtraction is taken the true difference is below 2^W,
  // so W-bit modular arithmetic gives the exact result.
  assign w_diff  = w_partial[W-1:0] - divisor_mag;
  assign q_bit   = (w_partial >= {1'b0, divisor_mag});
  assign rem_out = q_bit ? w_diff : w_partial[W-1:0];

endmodule

// File: rtl/tp_sdiv_32s_17s_18s_seq.sv
// Sequential signed divider: 32s / 17s -> 18s saturated quotient, 17s remainder.
// Radix-2 restoring, one quotient bit per cycle, valid/ready on both sides.
module tp_sdiv_32s_17s_18s_seq
  import tp_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W,
  parameter int QUOT_W     = DEF_QUOT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int                     L_CNT_W   = $clog2(DIVIDEND_W);
  localparam logic [L_CNT_W-1:0]     CNT_INIT  = L_CNT_W'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W-1:0]  POS_LIMIT = DIVIDEND_W'((64'd1 << (QUOT_W - 1)) - 64'd1);
  localparam logic [DIVIDEND_W-1:0]  NEG_LIMIT = DIVIDEND_W'(64'd1 << (QUOT_W - 1));
  localparam logic [QUOT_W-1:0]      SAT_POS   = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]      SAT_NEG   = {1'b1, {(QUOT_W-1){1'b0}}};

  state_t                r_state;
  state_t                w_state_next;

  logic                  r_dvd_sign;
  logic                  r_dsr_sign;
  logic                  r_dz;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB;
  // after DIVIDEND_W steps this holds the quotient magnitude.
  logic [DIVIDEND_W-1:0] r_dq;
  logic [DIVISOR_W-1:0]  r_dsr_mag;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [L_CNT_W-1:0]    r_cnt;

  logic [QUOT_W-1:0]     r_quot;
  logic [DIVISOR_W-1:0]  r_rem_out;
  logic                  r_ovf;
  logic                  r_dbz;

  logic [DIVIDEND_W-1:0] w_dvd_mag;
  logic [DIVISOR_W-1:0]  w_dsr_mag;
  logic                  w_dsr_zero;
  logic                  w_accept;
  logic [DIVISOR_W-1:0]  w_step_rem;
  logic                  w_step_q;
  logic [QUOT_W-1:0]     w_quot_fix;
  logic [DIVISOR_W-1:0]  w_rem_fix;
  logic                  w_ovf_fix;

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem_out;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;

  assign w_accept   = in_valid && in_ready;
  assign w_dsr_zero = (divisor == '0);
  // Two's-complement negation also maps the most negative value onto its
  // correct unsigned magnitude (e.g. -2^31 -> 2^31).
  assign w_dvd_mag  = dividend[DIVIDEND_W-1] ? (DIVIDEND_W'(0) - dividend) : dividend;
  assign w_dsr_mag  = divisor[DIVISOR_W-1]  ? (DIVISOR_W'(0) - divisor)   : divisor;

  tp_div_step #(
    .W (DIVISOR_W)
  ) u_step (
    .rem_in      (r_rem),
    .next_bit    (r_dq[DIVIDEND_W-1]),
    .divisor_mag (r_dsr_mag),
    .rem_out     (w_step_rem),
    .q_bit       (w_step_q)
  );

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_dsr_zero ? FIX : CALC;
      CALC:    if (r_cnt == '0) w_state_next = FIX;
      FIX:     w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Sign correction and saturation of the finished magnitudes.
  always_comb begin
    w_quot_fix = '0;
    w_rem_fix  = '0;
    w_ovf_fix  = 1'b0;
    if (r_dz) begin
      w_quot_fix = r_dvd_sign ? SAT_NEG : SAT_POS;
    end else begin
      if (r_dvd_sign ^ r_dsr_sign) begin
        if (r_dq > NEG_LIMIT) begin
          w_quot_fix = SAT_NEG;
          w_ovf_fix  = 1'b1;
        end else begin
          w_quot_fix = QUOT_W'(0) - r_dq[QUOT_W-1:0];
        end
      end else begin
        if (r_dq > POS_LIMIT) begin
          w_quot_fix = SAT_POS;
          w_ovf_fix  = 1'b1;
        end else begin
          w_quot_fix = r_dq[QUOT_W-1:0];
        end
      end
      // Remainder follows the dividend sign; a zero magnitude stays zero.
      w_rem_fix = r_dvd_sign ? (DIVISOR_W'(0) - r_rem) : r_rem;
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_dvd_sign <= 1'b0;
      r_dsr_sign <= 1'b0;
      r_dz       <= 1'b0;
      r_dq       <= '0;
      r_dsr_mag  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_quot     <= '0;
      r_rem_out  <= '0;
      r_ovf      <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dvd_sign <= dividend[DIVIDEND_W-1];
            r_dsr_sign <= divisor[DIVISOR_W-1];
            r_dz       <= w_dsr_zero;
            r_dq       <= w_dvd_mag;
            r_dsr_mag  <= w_dsr_mag;
            r_rem      <= '0;
            r_cnt      <= CNT_INIT;
          end
        end
        CALC: begin
          r_rem <= w_step_rem;
          r_dq  <= {r_dq[DIVIDEND_W-2:0], w_step_q};
          r_cnt <= r_cnt - L_CNT_W'(1);
        end
        FIX: begin
          r_quot    <= w_quot_fix;
          r_rem_out <= w_rem_fix;
          r_ovf     <= w_ovf_fix;
          r_dbz     <= r_dz;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tp_sdiv_32s_17s_18s_seq.sv
// Directed self-checking bench for the sequential signed divider.
// Latency is counted with the acceptance edge as cycle 1.
module tb_tp_sdiv_32s_17s_18s_seq;
  import tp_div_pkg::*;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [16:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] quotient;
  logic [16:0] remainder;
  logic        overflow;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  tp_sdiv_32s_17s_18s_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction: issue, wait for the result, optionally hold it
  // under back-pressure, then release it and confirm the return to idle.
  task automatic do_op(input logic signed [31:0] a, input logic signed [16:0] b,
                       input int eq, input int er, input logic eovf,
                       input logic edz, input int elat, input int hold,
                       input string tag);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    check({tag, ":in_ready"}, in_ready, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 17'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    check({tag, ":out_valid"}, out_valid, 1);
    if (elat != 0) check({tag, ":latency"}, lat, elat);
    check({tag, ":quotient"}, $signed(quotient), eq);
    check({tag, ":remainder"}, $signed(remainder), er);
    check({tag, ":overflow"}, overflow, eovf);
    check({tag, ":div_by_zero"}, div_by_zero, edz);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      dividend = 32'd999;
      divisor  = 17'd1;
      @(posedge ap_clk); #1;
      check({tag, ":hold_valid"}, out_valid, 1);
      check({tag, ":hold_in_ready"}, in_ready, 0);
      check({tag, ":hold_quotient"}, $signed(quotient), eq);
      check({tag, ":hold_remainder"}, $signed(remainder), er);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    check({tag, ":release_in_ready"}, in_ready, 1);
    check({tag, ":release_out_valid"}, out_valid, 0);
    $display("op %s: %0d / %0d -> q=%0d r=%0d ovf=%0b dz=%0b lat=%0d",
             tag, a, b, $signed(quotient), $signed(remainder), overflow, div_by_zero, lat);
  endtask

  initial begin
    int     ra;
    int     rb;
    longint rp;
    int     seen_valid;

    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state.
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst:in_ready", in_ready, 1);
    check("rst:out_valid", out_valid, 0);
    check("rst:quotient", $signed(quotient), 0);
    check("rst:remainder", $signed(remainder), 0);
    check("rst:overflow", overflow, 0);
    check("rst:div_by_zero", div_by_zero, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Basic divide with latency.
    do_op(32'sd1000000, 17'sd250, 4000, 0, 1'b0, 1'b0, 34, 0, "basic");
    // Sign combinations.
    do_op(-32'sd7, 17'sd2, -3, -1, 1'b0, 1'b0, 34, 0, "m7_p2");
    do_op(32'sd7, -17'sd2, -3, 1, 1'b0, 1'b0, 34, 0, "p7_m2");
    do_op(-32'sd7, -17'sd2, 3, -1, 1'b0, 1'b0, 34, 0, "m7_m2");
    do_op(32'sd6, -17'sd3, -2, 0, 1'b0, 1'b0, 34, 0, "p6_m3");
    // Saturation boundaries.
    do_op(32'sd2147483647, 17'sd1, QUOT_MAX, 0, 1'b1, 1'b0, 34, 0, "sat_pos");
    do_op(32'h80000000, 17'sd1, QUOT_MIN, 0, 1'b1, 1'b0, 34, 0, "sat_neg");
    do_op(-32'sd131072, 17'sd1, QUOT_MIN, 0, 1'b0, 1'b0, 34, 0, "min_exact");
    do_op(32'sd131072, 17'sd1, QUOT_MAX, 0, 1'b1, 1'b0, 34, 0, "pos_just_over");
    do_op(32'sd131071, 17'sd1, QUOT_MAX, 0, 1'b0, 1'b0, 34, 0, "max_exact");
    // Extreme divisor and remainder magnitudes.
    do_op(32'h80000000, 17'h10000, 32768, 0, 1'b0, 1'b0, 34, 0, "min_by_min");
    do_op(32'sd100, 17'h10000, 0, 100, 1'b0, 1'b0, 34, 0, "small_by_min");
    do_op(-32'sd100, 17'h10000, 0, -100, 1'b0, 1'b0, 34, 0, "neg_small_by_min");
    do_op(32'sd2147483647, 17'h10000, -32767, 65535, 1'b0, 1'b0, 34, 0, "max_rem");
    // Zero divisor.
    do_op(-32'sd5, 17'sd0, QUOT_MIN, 0, 1'b0, 1'b1, 2, 0, "m5_by_0");
    do_op(32'sd5, 17'sd0, QUOT_MAX, 0, 1'b0, 1'b1, 2, 0, "p5_by_0");
    do_op(32'sd0, 17'sd0, QUOT_MAX, 0, 1'b0, 1'b1, 2, 0, "z_by_0");
    // Back-pressure: hold DONE for 10 cycles with in_valid pulses.
    do_op(32'sd100, 17'sd7, 14, 2, 1'b0, 1'b0, 34, 10, "backpressure");

    // Reset in the middle of CALC after 10 iterations.
    dividend = 32'sd1000;
    divisor  = 17'sd3;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("midrst:out_valid", out_valid, 0);
    check("midrst:in_ready", in_ready, 1);
    check("midrst:quotient", $signed(quotient), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge ap_clk); #1;
      if (out_valid) seen_valid++;
    end
    check("midrst:no_output", seen_valid, 0);
    check("midrst:in_ready_after", in_ready, 1);
    $display("op midrst: reset during CALC, valid cycles seen=%0d", seen_valid);

    // Random exact products: a * b / b must give a with zero remainder.
    for (int n = 0; n < 1000; n++) begin
      ra = int'($urandom_range(0, 262143)) - 131072;
      rb = int'($urandom_range(0, 131070)) - 65536;
      if (rb >= 0) rb++;
      rp = longint'(ra) * longint'(rb);
      while (rp > 64'sd2147483647 || rp < -64'sd2147483648) begin
        ra = ra / 2;
        rp = longint'(ra) * longint'(rb);
      end
      do_op(32'(rp), 17'(rb), ra, 0, 1'b0, 1'b0, 0, 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
